// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_pkg / dmem_arbiter
//
// Two-port round-robin arbiter in front of the single data_memory command port.
// Port 0 is the core LSU, port 1 is debug/DMA. One request is accepted per
// cycle. Each accepted request is checked for alignment and becomes a
// registered memory command in the following cycle. A one-cycle response is
// returned one cycle after that, routed back to the requester by a port tag.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-port handshake [1:0]
//   req_addr/wdata/we/width/unsigned   per-port command fields
//   rsp_valid[1:0], rsp_rdata, rsp_err  response (one port per cycle)
//   data_addr, data_write_data, data_write_enable, mem_width, mem_unsigned
//                      command to data_memory (all zero when idle)
//   data_read_data     read data returned by data_memory
//   acc_cnt[1:0], err_cnt   saturating statistics counters
// -----------------------------------------------------------------------------
package riscv_pkg;
   parameter int XLEN      = 32;
   parameter int DMEM_SIZE = 4096;
endpackage

module dmem_arbiter #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int AW   = $clog2(riscv_pkg::DMEM_SIZE)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0][AW-1:0]        req_addr,
   input  logic [1:0][XLEN-1:0]      req_wdata,
   input  logic [1:0]                req_we,
   input  logic [1:0][2:0]           req_width,
   input  logic [1:0]                req_unsigned,
   output logic [1:0]                rsp_valid,
   output logic [XLEN-1:0]           rsp_rdata,
   output logic                      rsp_err,
   output logic [AW-1:0]             data_addr,
   output logic [XLEN-1:0]           data_write_data,
   output logic                      data_write_enable,
   output logic [2:0]                mem_width,
   output logic                      mem_unsigned,
   input  logic [XLEN-1:0]           data_read_data,
   output logic [1:0][15:0]          acc_cnt,
   output logic [15:0]               err_cnt
);

   // ---------------------------------------------------------------- arbitration
   // rr_q names the port that wins when both are valid; it flips to the other
   // port on every acceptance so the most recently served port loses next.
   logic       rr_q, rr_d;
   logic [1:0] gnt;
   logic       acc;
   logic       gnt_port;

   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         unique case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign req_ready = gnt;
   assign acc       = |(req_valid & gnt);
   assign gnt_port  = gnt[1];
   assign rr_d      = acc ? ~gnt_port : rr_q;

   // ---------------------------------------------------------------- legality
   logic [AW-1:0]   sel_addr;
   logic [XLEN-1:0] sel_wdata;
   logic            sel_we;
   logic [2:0]      sel_width;
   logic            sel_uns;
   logic            sel_legal;

   assign sel_addr  = req_addr[gnt_port];
   assign sel_wdata = req_wdata[gnt_port];
   assign sel_we    = req_we[gnt_port];
   assign sel_width = req_width[gnt_port];
   assign sel_uns   = req_unsigned[gnt_port];

   always_comb begin
      unique case (sel_width)
         3'b000:  sel_legal = 1'b1;
         3'b001:  sel_legal = ~sel_addr[0];
         3'b010:  sel_legal = (sel_addr[1:0] == 2'b00);
         default: sel_legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- command stage
   // Only legal accepted requests reach the memory port; otherwise it idles at 0.
   logic [AW-1:0]   cmd_addr_q,  cmd_addr_d;
   logic [XLEN-1:0] cmd_wdata_q, cmd_wdata_d;
   logic            cmd_we_q,    cmd_we_d;
   logic [2:0]      cmd_width_q, cmd_width_d;
   logic            cmd_uns_q,   cmd_uns_d;
   logic            cmd_vld_q;   // something accepted last cycle (legal or not)
   logic            cmd_tag_q;   // its port
   logic            cmd_ill_q;   // it was illegal

   always_comb begin
      cmd_addr_d  = '0;
      cmd_wdata_d = '0;
      cmd_we_d    = 1'b0;
      cmd_width_d = 3'b000;
      cmd_uns_d   = 1'b0;
      if (acc && sel_legal) begin
         cmd_addr_d  = sel_addr;
         cmd_wdata_d = sel_wdata;
         cmd_we_d    = sel_we;
         cmd_width_d = sel_width;
         cmd_uns_d   = sel_uns;
      end
   end

   assign data_addr         = cmd_addr_q;
   assign data_write_data   = cmd_wdata_q;
   assign data_write_enable = cmd_we_q;
   assign mem_width         = cmd_width_q;
   assign mem_unsigned      = cmd_uns_q;

   // ---------------------------------------------------------------- response stage
   logic [1:0]      rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q,   rsp_err_d;

   always_comb begin
      rsp_valid_d = 2'b00;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      if (cmd_vld_q) begin
         rsp_valid_d = cmd_tag_q ? 2'b10 : 2'b01;
         rsp_err_d   = cmd_ill_q;
         // cmd_we_q is already zero for illegal commands, so a legal read is
         // exactly "not illegal and not a write".
         if (!cmd_ill_q && !cmd_we_q)
            rsp_rdata_d = data_read_data;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // ---------------------------------------------------------------- counters
   logic [1:0][15:0] acc_cnt_q, acc_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   for (genvar i = 0; i < 2; i++) begin : g_acc
      assign acc_cnt_d[i] = (acc && (gnt_port == i[0]) && (acc_cnt_q[i] != 16'hFFFF))
                            ? acc_cnt_q[i] + 16'd1 : acc_cnt_q[i];
   end

   assign err_cnt_d = (acc && !sel_legal && (err_cnt_q != 16'hFFFF))
                      ? err_cnt_q + 16'd1 : err_cnt_q;

   assign acc_cnt = acc_cnt_q;
   assign err_cnt = err_cnt_q;

   // ---------------------------------------------------------------- state
   // Async reset clears every stage, which also drops commands in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_we_q    <= 1'b0;
         cmd_width_q <= 3'b000;
         cmd_uns_q   <= 1'b0;
         cmd_vld_q   <= 1'b0;
         cmd_tag_q   <= 1'b0;
         cmd_ill_q   <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         acc_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         rr_q        <= rr_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_we_q    <= cmd_we_d;
         cmd_width_q <= cmd_width_d;
         cmd_uns_q   <= cmd_uns_d;
         cmd_vld_q   <= acc;
         cmd_tag_q   <= gnt_port;
         cmd_ill_q   <= acc && !sel_legal;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         acc_cnt_q   <= acc_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter -- directed bench for dmem_arbiter with a byte-addressed
// data_memory model (combinational read with sign/zero extension, write on the
// rising edge). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 12;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0][AW-1:0]   req_addr;
   logic [1:0][XLEN-1:0] req_wdata;
   logic [1:0]           req_we;
   logic [1:0][2:0]      req_width;
   logic [1:0]           req_unsigned;
   logic [1:0]           rsp_valid;
   logic [XLEN-1:0]      rsp_rdata;
   logic                 rsp_err;
   logic [AW-1:0]        data_addr;
   logic [XLEN-1:0]      data_write_data;
   logic                 data_write_enable;
   logic [2:0]           mem_width;
   logic                 mem_unsigned;
   logic [XLEN-1:0]      data_read_data;
   logic [1:0][15:0]     acc_cnt;
   logic [15:0]          err_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_we           (req_we),
      .req_width        (req_width),
      .req_unsigned     (req_unsigned),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_err          (rsp_err),
      .data_addr        (data_addr),
      .data_write_data  (data_write_data),
      .data_write_enable(data_write_enable),
      .mem_width        (mem_width),
      .mem_unsigned     (mem_unsigned),
      .data_read_data   (data_read_data),
      .acc_cnt          (acc_cnt),
      .err_cnt          (err_cnt)
   );

   // ------------------------------------------------------------ memory model
   logic [7:0]    mem [0:4095];
   logic          mem_clr;
   logic [AW-1:0] a1, a2, a3;

   assign a1 = data_addr + 12'd1;
   assign a2 = data_addr + 12'd2;
   assign a3 = data_addr + 12'd3;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
      end else if (data_write_enable) begin
         mem[data_addr] <= data_write_data[7:0];
         if (mem_width != 3'b000) mem[a1] <= data_write_data[15:8];
         if (mem_width == 3'b010) begin
            mem[a2] <= data_write_data[23:16];
            mem[a3] <= data_write_data[31:24];
         end
      end
   end

   always_comb begin
      data_read_data = '0;
      case (mem_width)
         3'b000: data_read_data = mem_unsigned ? {24'h0, mem[data_addr]}
                                               : {{24{mem[data_addr][7]}}, mem[data_addr]};
         3'b001: data_read_data = mem_unsigned ? {16'h0, mem[a1], mem[data_addr]}
                                               : {{16{mem[a1][7]}}, mem[a1], mem[data_addr]};
         3'b010: data_read_data = {mem[a3], mem[a2], mem[a1], mem[data_addr]};
         default: data_read_data = '0;
      endcase
   end

   // ------------------------------------------------------------ checking
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // One complete transaction on port p: grant in N, command in N+1,
   // response in N+2, idle response in N+3.
   task automatic run_req(input logic p, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic we, input logic [2:0] w, input logic u,
                          input logic [31:0] erd, input logic eerr, input string tag);
      @(posedge clk); #1;
      req_addr[p]     = a;
      req_wdata[p]    = wd;
      req_we[p]       = we;
      req_width[p]    = w;
      req_unsigned[p] = u;
      req_valid       = p ? 2'b10 : 2'b01;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(req_ready), p ? 32'h2 : 32'h1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk({tag, "_dwe"},   32'(data_write_enable), 32'(we & ~eerr));
      chk({tag, "_daddr"}, 32'(data_addr), eerr ? 32'h0 : 32'(a));
      chk({tag, "_dwdat"}, data_write_data, eerr ? 32'h0 : wd);
      chk({tag, "_mwid"},  32'(mem_width), eerr ? 32'h0 : 32'(w));
      @(negedge clk);
      chk({tag, "_rspv"},  32'(rsp_valid), p ? 32'h2 : 32'h1);
      chk({tag, "_rdata"}, rsp_rdata, erd);
      chk({tag, "_err"},   32'(rsp_err), 32'(eerr));
      @(negedge clk);
      chk({tag, "_rspv_idle"},  32'(rsp_valid), 32'h0);
      chk({tag, "_rdata_idle"}, rsp_rdata, 32'h0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      rst_n        = 1'b0;
      mem_clr      = 1'b1;
      req_valid    = 2'b11;
      req_addr     = '0;
      req_wdata    = '0;
      req_we       = '0;
      req_width    = '0;
      req_unsigned = '0;

      repeat (2) @(posedge clk);
      #1 mem_clr = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rspv",  32'(rsp_valid), 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err",   32'(rsp_err), 32'h0);
      chk("rst_dwe",   32'(data_write_enable), 32'h0);
      chk("rst_daddr", 32'(data_addr), 32'h0);
      chk("rst_acc0",  32'(acc_cnt[0]), 32'h0);
      chk("rst_acc1",  32'(acc_cnt[1]), 32'h0);
      chk("rst_errc",  32'(err_cnt), 32'h0);
      req_valid = 2'b00;
      @(posedge clk); #1 rst_n = 1'b1;

      // word write then read back
      run_req(1'b0, 12'h010, 32'hDEADBEEF, 1'b1, 3'b010, 1'b0, 32'h0, 1'b0, "sw");
      run_req(1'b0, 12'h010, 32'h0, 1'b0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0, "lw");
      // misaligned halfword read on port 1
      run_req(1'b1, 12'h003, 32'h0, 1'b0, 3'b001, 1'b0, 32'h0, 1'b1, "lh_mis");
      chk("errc_1", 32'(err_cnt), 32'h1);
      // byte store, signed and unsigned loads
      run_req(1'b0, 12'h021, 32'h00000080, 1'b1, 3'b000, 1'b0, 32'h0, 1'b0, "sb");
      run_req(1'b0, 12'h021, 32'h0, 1'b0, 3'b000, 1'b0, 32'hFFFFFF80, 1'b0, "lb");
      run_req(1'b0, 12'h021, 32'h0, 1'b0, 3'b000, 1'b1, 32'h00000080, 1'b0, "lbu");
      // halfword store, signed and unsigned loads
      run_req(1'b0, 12'h030, 32'h00008001, 1'b1, 3'b001, 1'b0, 32'h0, 1'b0, "sh");
      run_req(1'b0, 12'h030, 32'h0, 1'b0, 3'b001, 1'b0, 32'hFFFF8001, 1'b0, "lh");
      run_req(1'b0, 12'h030, 32'h0, 1'b0, 3'b001, 1'b1, 32'h00008001, 1'b0, "lhu");
      // misaligned word write must not touch memory
      run_req(1'b0, 12'h012, 32'hCAFEBABE, 1'b1, 3'b010, 1'b0, 32'h0, 1'b1, "sw_mis");
      run_req(1'b0, 12'h010, 32'h0, 1'b0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0, "lw_after");
      chk("acc0_10", 32'(acc_cnt[0]), 32'd10);
      chk("acc1_1",  32'(acc_cnt[1]), 32'd1);
      chk("errc_2",  32'(err_cnt), 32'd2);

      // reset in the cycle after a write is accepted
      @(posedge clk); #1;
      req_addr[0] = 12'h040; req_wdata[0] = 32'h55AA55AA;
      req_we[0] = 1'b1; req_width[0] = 3'b010; req_unsigned[0] = 1'b0;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("inflt_dwe_pre", 32'(data_write_enable), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("inflt_dwe",   32'(data_write_enable), 32'h0);
      chk("inflt_daddr", 32'(data_addr), 32'h0);
      chk("inflt_acc0",  32'(acc_cnt[0]), 32'h0);
      chk("inflt_acc1",  32'(acc_cnt[1]), 32'h0);
      chk("inflt_errc",  32'(err_cnt), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("inflt_no_rsp", 32'(rsp_valid), 32'h0);
      end
      chk("inflt_mem", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]}, 32'h0);

      // both ports valid from the first cycle after a fresh reset release
      req_we       = 2'b00;
      req_width[0] = 3'b010; req_width[1] = 3'b010;
      req_unsigned = 2'b00;
      req_addr[0]  = 12'h010; req_addr[1] = 12'h020;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      req_valid = 2'b11;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 4) chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         if (i >= 2 && i < 6) begin
            chk("rr_rspv",  32'(rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", rsp_rdata, (i % 2 == 0) ? 32'hDEADBEEF : 32'h00008000);
         end
         if (i == 6) chk("rr_rspv_idle", 32'(rsp_valid), 32'h0);
         @(posedge clk); #1;
         if (i == 3) req_valid = 2'b00;
      end
      chk("rr_acc0", 32'(acc_cnt[0]), 32'd2);
      chk("rr_acc1", 32'(acc_cnt[1]), 32'd2);
      chk("rr_errc", 32'(err_cnt), 32'd0);

      // back-to-back port 0 traffic into saturation
      req_valid = 2'b01;
      repeat (65532) @(posedge clk);
      #1;
      chk("sat_pre", 32'(acc_cnt[0]), 32'h0000FFFE);
      repeat (70000 - 65532) @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_acc0", 32'(acc_cnt[0]), 32'h0000FFFF);
      chk("sat_acc1", 32'(acc_cnt[1]), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
